fpu_ss_cmem_obi: RTL and testbench



---
 rtl/acc_pkg.sv | 18 +
 rtl/fpu_ss_pkg.sv | 42 ++++
 rtl/fpu_ss_cmem_obi_fifo.sv | 93 +++++++++
 rtl/fpu_ss_cmem_obi.sv | 236 +++++++++++++++++++++++
 tb/tb_fpu_ss_cmem_obi.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Accelerator-interface types shared with the core-side
//                request/response channels (request type, address width).
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

   localparam int AddrWidth = 32;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_req_type_e;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/fpu_ss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_ss_pkg
//  Description : FPU-subsystem shared definitions: load/store width
//                encodings, cmem meta/response records, range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_ss_pkg;

   localparam logic [2:0] LS_BYTE = 3'b000;
   localparam logic [2:0] LS_HALF = 3'b001;
   localparam logic [2:0] LS_WORD = 3'b010;

   // Per-transaction context kept while the OBI access is outstanding.
   typedef struct packed {
      logic                            we;
      logic [2:0]                      width;
      logic [1:0]                      off;
      logic [acc_pkg::AddrWidth-1:0]   addr;
      logic [31:0]                     hart_id;
   } cmem_meta_t;

   // Fully formed response as presented on the cmem_p channel.
   typedef struct packed {
      logic [31:0]                     rdata;
      logic [4:0]                      range;
      logic                            status;
      logic [acc_pkg::AddrWidth-1:0]   addr;
      logic [31:0]                     hart_id;
   } cmem_rsp_t;

   // Index of the last valid byte; unsupported widths report a full word.
   function automatic logic [4:0] ls_range(input logic [2:0] width);
      case (width)
         LS_BYTE: return 5'd0;
         LS_HALF: return 5'd1;
         default: return 5'd3;
      endcase
   endfunction

endpackage : fpu_ss_pkg
`default_nettype wire

// File: rtl/fpu_ss_cmem_obi_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo
//  Description : Valid/ready style FIFO with occupancy output and optional
//                fall-through when empty.
//  Ports       : clk_i, rst_ni        clock, async active-low reset
//                push_i, data_i       write side
//                full_o               no free slot
//                pop_i, data_o        read side (pop only when valid_o)
//                valid_o              head entry available
//                usage_o              number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 2,
   parameter bit FALL_THROUGH = 1'b0,
   parameter int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  full_o,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic [CNT_W-1:0]      usage_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic w_empty;
   logic w_bypass;
   logic w_do_push;
   logic w_do_pop;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_empty = (r_count == '0);
   assign full_o  = (r_count == CNT_W'(DEPTH));
   assign usage_o = r_count;

   generate
      if (FALL_THROUGH) begin : g_fall_through
         // An entry pushed into an empty FIFO is visible the same cycle;
         // if it is also popped it never touches storage.
         assign valid_o  = ~w_empty | push_i;
         assign data_o   = w_empty ? data_i : r_mem[r_rd_ptr];
         assign w_bypass = w_empty & push_i & pop_i;
      end else begin : g_registered
         assign valid_o  = ~w_empty;
         assign data_o   = r_mem[r_rd_ptr];
         assign w_bypass = 1'b0;
      end
   endgenerate

   assign w_do_push = push_i & ~w_bypass & (~full_o | pop_i);
   assign w_do_pop  = pop_i & valid_o & ~w_bypass;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
            r_wr_ptr        <= f_next(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : stream_fifo
`default_nettype wire

// File: rtl/fpu_ss_cmem_obi.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_ss_cmem_obi
//  Description : FPU-subsystem memory stage. Turns cmem load/store requests
//                into OBI data-port accesses and returns in-order responses
//                with aligned, NaN-boxed load data.
//  Ports       : clk_i, rst_ni            clock, async active-low reset
//                cmem_q_*                 request channel (valid/ready)
//                cmem_p_*                 response channel (valid/ready)
//                data_req_o..data_wdata_o OBI address phase
//                data_rvalid_i..data_err_i OBI response phase
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_ss_cmem_obi
   import acc_pkg::*;
   import fpu_ss_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   // cmem request
   input  logic                 cmem_q_valid_i,
   output logic                 cmem_q_ready_o,
   input  logic [31:0]          cmem_q_laddr_i,
   input  logic [31:0]          cmem_q_wdata_i,
   input  logic [2:0]           cmem_q_width_i,
   input  mem_req_type_e        cmem_q_req_type_i,
   input  logic [31:0]          cmem_q_hart_id_i,
   input  logic [AddrWidth-1:0] cmem_q_addr_i,
   // cmem response
   output logic                 cmem_p_valid_o,
   input  logic                 cmem_p_ready_i,
   output logic [31:0]          cmem_p_rdata_o,
   output logic [4:0]           cmem_p_range_o,
   output logic                 cmem_p_status_o,
   output logic [AddrWidth-1:0] cmem_p_addr_o,
   output logic [31:0]          cmem_p_hart_id_o,
   // OBI data port
   output logic                 data_req_o,
   input  logic                 data_gnt_i,
   output logic [31:0]          data_addr_o,
   output logic                 data_we_o,
   output logic [3:0]           data_be_o,
   output logic [31:0]          data_wdata_o,
   input  logic                 data_rvalid_i,
   input  logic [31:0]          data_rdata_i,
   input  logic                 data_err_i
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_W-1:0] r_inflight;
   logic             r_post_rst;

   logic [CNT_W:0]   w_used;
   logic             w_credit;
   logic             w_legal;
   logic             w_obi_acc;
   logic             w_local_acc;
   logic             w_rvalid_ok;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_shifted;

   cmem_meta_t       w_meta_in;
   cmem_meta_t       w_meta_out;
   logic             w_meta_full;
   logic             w_meta_valid;
   logic [CNT_W-1:0] w_meta_usage;

   cmem_rsp_t        w_rsp_in;
   cmem_rsp_t        w_rsp_out;
   logic             w_rsp_push;
   logic             w_rsp_pop;
   logic             w_rsp_full;
   logic [CNT_W-1:0] w_rsp_usage;

   // Buffered responses hold credit too, so a stalled core can never make
   // the response FIFO overflow when the bus answers.
   assign w_used   = {1'b0, r_inflight} + {1'b0, w_rsp_usage};
   assign w_credit = (w_used < (CNT_W + 1)'(MAX_OUTSTANDING));

   always_comb begin
      w_legal = 1'b0;
      case (cmem_q_width_i)
         LS_BYTE: w_legal = 1'b1;
         LS_HALF: w_legal = ~cmem_q_laddr_i[0];
         LS_WORD: w_legal = (cmem_q_laddr_i[1:0] == 2'b00);
         default: w_legal = 1'b0;
      endcase
   end

   assign data_req_o  = cmem_q_valid_i & w_legal & w_credit;
   assign w_obi_acc   = data_req_o & data_gnt_i;
   // Illegal requests wait for the bus to drain so their error response
   // cannot overtake older loads/stores.
   assign w_local_acc = cmem_q_valid_i & ~w_legal & w_credit & (r_inflight == '0);
   assign cmem_q_ready_o = w_obi_acc | w_local_acc;

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = '0;
      case (cmem_q_width_i)
         LS_BYTE: begin
            w_be    = 4'b0001 << cmem_q_laddr_i[1:0];
            w_wdata = {4{cmem_q_wdata_i[7:0]}};
         end
         LS_HALF: begin
            w_be    = 4'b0011 << cmem_q_laddr_i[1:0];
            w_wdata = {2{cmem_q_wdata_i[15:0]}};
         end
         LS_WORD: begin
            w_be    = 4'b1111;
            w_wdata = cmem_q_wdata_i;
         end
         default: ;
      endcase
   end

   // Address phase is held at zero whenever no request is presented.
   assign data_addr_o  = data_req_o ? {cmem_q_laddr_i[31:2], 2'b00} : '0;
   assign data_we_o    = data_req_o & (cmem_q_req_type_i == WRITE);
   assign data_be_o    = data_req_o ? w_be : '0;
   assign data_wdata_o = data_req_o ? w_wdata : '0;

   assign w_meta_in.we      = (cmem_q_req_type_i == WRITE);
   assign w_meta_in.width   = cmem_q_width_i;
   assign w_meta_in.off     = cmem_q_laddr_i[1:0];
   assign w_meta_in.addr    = cmem_q_addr_i;
   assign w_meta_in.hart_id = cmem_q_hart_id_i;

   // A response with nothing outstanding has no owner and is dropped.
   assign w_rvalid_ok = data_rvalid_i & (r_inflight != '0);

   always_comb begin
      w_shifted = data_rdata_i >> {w_meta_out.off, 3'b000};
      w_rsp_in  = '0;
      if (w_rvalid_ok) begin
         w_rsp_in.addr    = w_meta_out.addr;
         w_rsp_in.hart_id = w_meta_out.hart_id;
         w_rsp_in.range   = ls_range(w_meta_out.width);
         w_rsp_in.status  = data_err_i;
         if (!w_meta_out.we) begin
            case (w_meta_out.width)
               LS_BYTE: w_rsp_in.rdata = {24'hFFFFFF, w_shifted[7:0]};
               LS_HALF: w_rsp_in.rdata = {16'hFFFF, w_shifted[15:0]};
               default: w_rsp_in.rdata = data_rdata_i;
            endcase
         end
      end else begin
         w_rsp_in.addr    = cmem_q_addr_i;
         w_rsp_in.hart_id = cmem_q_hart_id_i;
         w_rsp_in.range   = ls_range(cmem_q_width_i);
         w_rsp_in.status  = 1'b1;
      end
   end

   // Local accepts need in-flight = 0 and bus responses need in-flight > 0,
   // so at most one source pushes a response per cycle.
   assign w_rsp_push = w_rvalid_ok | w_local_acc;
   assign w_rsp_pop  = cmem_p_valid_o & cmem_p_ready_i;

   stream_fifo #(
      .DATA_WIDTH   ($bits(cmem_meta_t)),
      .DEPTH        (MAX_OUTSTANDING),
      .FALL_THROUGH (1'b0)
   ) u_meta_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_obi_acc),
      .data_i  (w_meta_in),
      .full_o  (w_meta_full),
      .pop_i   (w_rvalid_ok),
      .data_o  (w_meta_out),
      .valid_o (w_meta_valid),
      .usage_o (w_meta_usage)
   );

   stream_fifo #(
      .DATA_WIDTH   ($bits(cmem_rsp_t)),
      .DEPTH        (MAX_OUTSTANDING),
      .FALL_THROUGH (1'b0)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_rsp_push),
      .data_i  (w_rsp_in),
      .full_o  (w_rsp_full),
      .pop_i   (w_rsp_pop),
      .data_o  (w_rsp_out),
      .valid_o (cmem_p_valid_o),
      .usage_o (w_rsp_usage)
   );

   assign cmem_p_rdata_o   = w_rsp_out.rdata;
   assign cmem_p_range_o   = w_rsp_out.range;
   assign cmem_p_status_o  = w_rsp_out.status;
   assign cmem_p_addr_o    = w_rsp_out.addr;
   assign cmem_p_hart_id_o = w_rsp_out.hart_id;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_inflight <= '0;
      end else begin
         case ({w_obi_acc, w_rvalid_ok})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Transactions abandoned by a reset may still be answered by the bus.
   // Such late responses are expected until the first new access is granted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_post_rst <= 1'b1;
      end else if (w_obi_acc) begin
         r_post_rst <= 1'b0;
      end
   end

   a_no_orphan_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(data_rvalid_i && (r_inflight == '0) && !r_post_rst));
   a_meta_tracks_inflight : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (w_meta_usage == r_inflight));
   a_meta_room : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_obi_acc && w_meta_full));
   a_meta_present : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_rvalid_ok && !w_meta_valid));
   a_rsp_room : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_rsp_push && w_rsp_full && !w_rsp_pop));

endmodule : fpu_ss_cmem_obi
`default_nettype wire

// File: tb/tb_fpu_ss_cmem_obi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_ss_cmem_obi
//  Description : Scoreboard testbench for fpu_ss_cmem_obi with an OBI slave
//                model, directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_ss_cmem_obi;
   import acc_pkg::*;

   localparam int MAX_OUT = 2;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cmem_q_valid_i = 1'b0;
   logic          cmem_q_ready_o;
   logic [31:0]   cmem_q_laddr_i = '0;
   logic [31:0]   cmem_q_wdata_i = '0;
   logic [2:0]    cmem_q_width_i = '0;
   mem_req_type_e cmem_q_req_type_i = READ;
   logic [31:0]   cmem_q_hart_id_i = '0;
   logic [31:0]   cmem_q_addr_i = '0;
   logic          cmem_p_valid_o;
   logic          cmem_p_ready_i = 1'b0;
   logic [31:0]   cmem_p_rdata_o;
   logic [4:0]    cmem_p_range_o;
   logic          cmem_p_status_o;
   logic [31:0]   cmem_p_addr_o;
   logic [31:0]   cmem_p_hart_id_o;
   logic          data_req_o;
   logic          data_gnt_i = 1'b0;
   logic [31:0]   data_addr_o;
   logic          data_we_o;
   logic [3:0]    data_be_o;
   logic [31:0]   data_wdata_o;
   logic          data_rvalid_i = 1'b0;
   logic [31:0]   data_rdata_i = '0;
   logic          data_err_i = 1'b0;

   fpu_ss_cmem_obi #(.MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .cmem_q_valid_i    (cmem_q_valid_i),
      .cmem_q_ready_o    (cmem_q_ready_o),
      .cmem_q_laddr_i    (cmem_q_laddr_i),
      .cmem_q_wdata_i    (cmem_q_wdata_i),
      .cmem_q_width_i    (cmem_q_width_i),
      .cmem_q_req_type_i (cmem_q_req_type_i),
      .cmem_q_hart_id_i  (cmem_q_hart_id_i),
      .cmem_q_addr_i     (cmem_q_addr_i),
      .cmem_p_valid_o    (cmem_p_valid_o),
      .cmem_p_ready_i    (cmem_p_ready_i),
      .cmem_p_rdata_o    (cmem_p_rdata_o),
      .cmem_p_range_o    (cmem_p_range_o),
      .cmem_p_status_o   (cmem_p_status_o),
      .cmem_p_addr_o     (cmem_p_addr_o),
      .cmem_p_hart_id_o  (cmem_p_hart_id_o),
      .data_req_o        (data_req_o),
      .data_gnt_i        (data_gnt_i),
      .data_addr_o       (data_addr_o),
      .data_we_o         (data_we_o),
      .data_be_o         (data_be_o),
      .data_wdata_o      (data_wdata_o),
      .data_rvalid_i     (data_rvalid_i),
      .data_rdata_i      (data_rdata_i),
      .data_err_i        (data_err_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  rng;
      logic        status;
      logic [31:0] addr;
      logic [31:0] hart;
   } exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } pend_t;

   exp_t  exp_q[$];
   pend_t pend_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // current request presented upstream, plus the bus answer it will get
   logic [31:0] cur_laddr, cur_wdata, cur_hart, cur_addr, cur_rdata;
   logic [2:0]  cur_width;
   logic        cur_we, cur_err, cur_legal;

   int gnt_mode   = 1;   // 1: always grant, otherwise random
   int rdy_mode   = 1;   // 0: hold low, 1: always ready, otherwise random
   bit slave_hold = 1'b0;
   bit spurious   = 1'b0;
   bit lat_chk    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_legal(input logic [31:0] la, input logic [2:0] w);
      if (w > 3'd2) return 1'b0;
      return (la % (32'd1 << w)) == 32'd0;
   endfunction

   function automatic exp_t model(input logic [31:0] la, input logic [2:0] w, input logic we,
                                  input logic [31:0] hart, input logic [31:0] addr,
                                  input logic [31:0] rd, input logic err);
      exp_t e;
      int size, off;
      logic [7:0]  b [4];
      logic [31:0] v, mask;
      e.addr = addr;
      e.hart = hart;
      if (!is_legal(la, w)) begin
         e.status = 1'b1;
         e.rdata  = '0;
         e.rng    = (w == 3'd0) ? 5'd0 : (w == 3'd1) ? 5'd1 : 5'd3;
         return e;
      end
      size     = 1 << w;
      off      = int'(la % 32'd4);
      e.rng    = 5'(size - 1);
      e.status = err;
      if (we) begin
         e.rdata = '0;
      end else begin
         for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
         v = '0;
         for (int k = 0; k < size; k++) v = v | (32'(b[off + k]) << (8 * k));
         mask    = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
         e.rdata = v | ~mask;
      end
      return e;
   endfunction

   function automatic logic [3:0] exp_be(input logic [31:0] la, input logic [2:0] w);
      logic [3:0] be;
      int size = 1 << w;
      int off  = int'(la % 32'd4);
      for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
      return be;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [31:0] wd, input logic [2:0] w);
      logic [31:0] r;
      int size = 1 << w;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
      return r;
   endfunction

   // ---------------- upstream driver ----------------
   task automatic present(input logic [31:0] la, input logic [2:0] w, input logic we,
                          input logic [31:0] wd, input logic [31:0] hart, input logic [31:0] addr,
                          input logic [31:0] rd, input logic err);
      cur_laddr = la;  cur_width = w;   cur_we  = we;  cur_wdata = wd;
      cur_hart  = hart; cur_addr = addr; cur_rdata = rd; cur_err = err;
      cur_legal = is_legal(la, w);
      cmem_q_laddr_i    = la;
      cmem_q_width_i    = w;
      cmem_q_req_type_i = we ? WRITE : READ;
      cmem_q_wdata_i    = wd;
      cmem_q_hart_id_i  = hart;
      cmem_q_addr_i     = addr;
      cmem_q_valid_i    = 1'b1;
   endtask

   task automatic wait_accept();
      bit done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk_i);
         if (!cur_legal) check("illegal_no_obi", 64'(data_req_o), 64'd0);
         if (cmem_q_ready_o) begin
            exp_q.push_back(model(cur_laddr, cur_width, cur_we, cur_hart, cur_addr,
                                  cur_rdata, cur_err));
            done = 1'b1;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got ready=0, expected ready=1 for laddr %0h", cur_laddr);
      end
      @(posedge clk_i); #1;
      cmem_q_valid_i = 1'b0;
   endtask

   task automatic issue(input logic [31:0] la, input logic [2:0] w, input logic we,
                        input logic [31:0] wd, input logic [31:0] hart, input logic [31:0] addr,
                        input logic [31:0] rd, input logic err);
      present(la, w, we, wd, hart, addr, rd, err);
      wait_accept();
   endtask

   task automatic wait_idle();
      int c = 0;
      while ((exp_q.size() != 0 || pend_q.size() != 0) && c < 1000) begin
         @(posedge clk_i); #1;
         c++;
      end
      if (c >= 1000) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d responses left, expected 0", exp_q.size());
      end
   endtask

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   // ---------------- OBI slave / core-side ready driver ----------------
   initial begin
      pend_t p;
      forever begin
         @(posedge clk_i); #1;
         data_rvalid_i  = 1'b0;
         data_err_i     = 1'b0;
         data_rdata_i   = $urandom;
         data_gnt_i     = (gnt_mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
         cmem_p_ready_i = (rdy_mode == 0) ? 1'b0 :
                          (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (!rst_ni) begin
            pend_q.delete();
         end else if (spurious) begin
            data_rvalid_i = 1'b1;
            spurious      = 1'b0;
         end else if (!slave_hold && pend_q.size() > 0 && (lat_chk || $urandom_range(0, 2) != 0)) begin
            p             = pend_q.pop_front();
            data_rvalid_i = 1'b1;
            data_rdata_i  = p.rdata;
            data_err_i    = p.err;
            if (lat_chk) begin
               fork
                  begin
                     @(negedge clk_i);
                     check("rsp_not_same_cycle", 64'(cmem_p_valid_o), 64'd0);
                     @(negedge clk_i);
                     check("rsp_latency", 64'(cmem_p_valid_o), 64'd1);
                  end
               join_none
            end
         end
      end
   end

   // ---------------- grant checker and response monitor ----------------
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_ni && data_req_o && data_gnt_i) begin
         check("obi_addr",  64'(data_addr_o),  64'({cur_laddr[31:2], 2'b00}));
         check("obi_we",    64'(data_we_o),    64'(cur_we));
         check("obi_be",    64'(data_be_o),    64'(exp_be(cur_laddr, cur_width)));
         if (cur_we) check("obi_wdata", 64'(data_wdata_o), 64'(exp_wd(cur_wdata, cur_width)));
         pend_q.push_back('{rdata: cur_rdata, err: cur_err});
      end
      if (rst_ni && cmem_p_valid_o && cmem_p_ready_i) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got response addr %0h, expected none", cmem_p_addr_o);
         end else begin
            e = exp_q.pop_front();
            check("rsp_rdata",  64'(cmem_p_rdata_o),   64'(e.rdata));
            check("rsp_range",  64'(cmem_p_range_o),   64'(e.rng));
            check("rsp_status", 64'(cmem_p_status_o),  64'(e.status));
            check("rsp_addr",   64'(cmem_p_addr_o),    64'(e.addr));
            check("rsp_hart",   64'(cmem_p_hart_id_o), 64'(e.hart));
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] la;
      logic [2:0]  w;
      int          r;

      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_p_valid", 64'(cmem_p_valid_o), 64'd0);
      check("rst_q_ready", 64'(cmem_q_ready_o), 64'd0);
      check("rst_req",     64'(data_req_o),     64'd0);
      check("rst_rdata",   64'(cmem_p_rdata_o), 64'd0);
      check("rst_hart",    64'(cmem_p_hart_id_o), 64'd0);
      step();
      rst_ni = 1'b1;
      step();

      // directed transactions, one at a time, with latency checks
      lat_chk = 1'b1;
      issue(32'h100, 3'b010, 1'b0, 32'h0,        32'd1, 32'hA000_0001, 32'h3F80_0000, 1'b0);
      wait_idle();
      issue(32'h202, 3'b001, 1'b1, 32'h0000_ABCD, 32'd2, 32'hA000_0002, 32'h0,        1'b0);
      wait_idle();
      issue(32'h103, 3'b000, 1'b0, 32'h0,        32'd3, 32'hA000_0003, 32'h7F00_0000, 1'b0);
      wait_idle();
      issue(32'h300, 3'b010, 1'b1, 32'h1234_5678, 32'd4, 32'hA000_0004, 32'h0,        1'b1);
      wait_idle();
      lat_chk = 1'b0;

      // credit exhaustion: two responses parked, third request must stall
      rdy_mode = 0;
      issue(32'h400, 3'b010, 1'b0, 32'h0, 32'd5, 32'hB000_0005, 32'h1111_1111, 1'b0);
      issue(32'h404, 3'b010, 1'b0, 32'h0, 32'd6, 32'hB000_0006, 32'h2222_2222, 1'b0);
      repeat (4) step();
      present(32'h408, 3'b010, 1'b0, 32'h0, 32'd7, 32'hB000_0007, 32'h3333_3333, 1'b0);
      repeat (6) begin
         @(negedge clk_i);
         check("full_no_req",   64'(data_req_o),     64'd0);
         check("full_no_ready", 64'(cmem_q_ready_o), 64'd0);
      end
      step();
      rdy_mode = 1;
      wait_accept();
      wait_idle();

      // misaligned access must wait behind an outstanding load
      slave_hold = 1'b1;
      issue(32'h500, 3'b010, 1'b0, 32'h0, 32'd8, 32'hC000_0008, 32'h5555_AAAA, 1'b0);
      present(32'h101, 3'b010, 1'b0, 32'h0, 32'd9, 32'hC000_0009, 32'h0, 1'b0);
      repeat (4) begin
         @(negedge clk_i);
         check("misalign_no_req",   64'(data_req_o),     64'd0);
         check("misalign_no_ready", 64'(cmem_q_ready_o), 64'd0);
      end
      step();
      slave_hold = 1'b0;
      wait_accept();
      wait_idle();

      // randomized traffic
      gnt_mode = 2;
      rdy_mode = 2;
      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 9);
         w  = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
         la = $urandom;
         if (w <= 3'd2 && $urandom_range(0, 9) != 0) la = la & ~((32'd1 << w) - 32'd1);
         issue(la, w, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
               ($urandom_range(0, 7) == 0));
         repeat ($urandom_range(0, 2)) step();
      end
      wait_idle();

      // reset with a load outstanding, then a late bus response
      gnt_mode   = 1;
      rdy_mode   = 1;
      slave_hold = 1'b1;
      issue(32'h600, 3'b010, 1'b0, 32'h0, 32'hDD, 32'hD000_00DD, 32'h7777_7777, 1'b0);
      rst_ni = 1'b0;
      exp_q.delete();
      repeat (2) step();
      rst_ni   = 1'b1;
      spurious = 1'b1;
      repeat (4) begin
         @(negedge clk_i);
         check("post_rst_no_rsp", 64'(cmem_p_valid_o),   64'd0);
         check("post_rst_rdata",  64'(cmem_p_rdata_o),   64'd0);
         check("post_rst_hart",   64'(cmem_p_hart_id_o), 64'd0);
         check("post_rst_req",    64'(data_req_o),       64'd0);
      end
      slave_hold = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_fpu_ss_cmem_obi
`default_nettype wire
